lifo_stack_ctrl: RTL and testbench
==================================

Name: lifo_stack_ctrl

Overview:
Parametrised LIFO stack for the memory/interface group. It is the successor to the basic single-port stack.
- Adds simultaneous push+pop (replace-top), an always-valid registered top-of-stack view, and an occupancy count.
- Adds an almost-full threshold, sticky overflow/underflow error flags and a synchronous clear.
- Used by expression evaluators, return-address stacks and backtracking engines.

Parameters:
DATA_WIDTH, 8, width of each stack entry
STACK_DEPTH, 16, number of entries; any value >= 2, non-power-of-two allowed
ADDR_WIDTH, 4, index width; must satisfy 2**ADDR_WIDTH >= STACK_DEPTH
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..STACK_DEPTH)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of stack contents and error flags
push  input  1  push request; writes din
pop  input  1  pop request
din  input  DATA_WIDTH  data to push
pop_data  output  DATA_WIDTH  registered popped value
pop_valid  output  1  one-cycle pulse; pop_data updated this cycle
top_data  output  DATA_WIDTH  registered current top entry; 0 when empty
count  output  ADDR_WIDTH+1  current occupancy, 0..STACK_DEPTH
empty  output  1  count == 0
full  output  1  count == STACK_DEPTH
almost_full  output  1  count >= AF_LEVEL
overflow  output  1  sticky: push rejected while full
underflow  output  1  sticky: pop rejected while empty
max_count  output  ADDR_WIDTH+1  high-watermark (see Optional Feature)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). Reset drives sp=0, pop_data=0, pop_valid=0, top_data=0, overflow=0, underflow=0 and max_count=0. Memory contents are not reset.
- count, empty, full and almost_full are combinational from the registered sp.
- All state updates occur on the rising edge of clk. Results are visible the cycle after the request, so latency is 1.
- clear has highest priority. It sets sp=0, top_data=0, pop_valid=0, overflow=0, underflow=0 and max_count=0. It ignores push and pop in the same cycle. pop_data holds its value.
- Push only, not full: mem[sp]<=din, sp<=sp+1, top_data<=din.
- Push only, full: no state change; overflow<=1.
- Pop only, not empty:
  - pop_data<=top_data, pop_valid<=1, sp<=sp-1.
  - top_data<=mem[sp-2] if sp>=2, else 0.
- Pop only, empty: no state change; underflow<=1; pop_valid stays 0.
- Push and pop, not empty (replace-top; legal when full):
  - mem[sp-1]<=din, pop_data<=top_data, pop_valid<=1.
  - top_data<=din; sp unchanged.
- Push and pop, empty: push executes as push-only; pop is rejected; underflow<=1; pop_valid=0.
- pop_valid is 0 in every cycle not listed above as asserting it.
- Error flags stay set until clear or reset. They never block operation.
- Memory read for the new top is combinational from mem; top_data is the only read path to the user.
- count never exceeds STACK_DEPTH and never wraps below 0.
- Reset asserted mid-operation aborts any in-flight push/pop immediately. Next cycle the stack is empty.

Optional Feature:
Macro STACK_WATERMARK_EN.
- Defined: max_count is a register updated each cycle to max(max_count, next count). It is cleared by reset or clear.
- Undefined: no register is built; max_count is tied to 0.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on 3 consecutive cycles -> count=3, top_data=0x33, empty=0; then pop x3 -> pop_data 0x33, 0x22, 0x11 each with pop_valid pulse; top_data goes 0x22, 0x11, 0x00; empty=1.
- Push 16 values 0x00..0x0F -> almost_full rises when count reaches 12, full=1 at 16. Then push 0xAA -> overflow=1, count=16, top_data=0x0F.
- Fill to 16, then push+pop with din=0x55 -> pop_data=0x0F, pop_valid=1, count=16, top_data=0x55. Then pop -> pop_data=0x55, top_data=0x0E.
- Empty stack: pop -> underflow=1, pop_valid=0. Same cycle push+pop din=0x7E -> count=1, top_data=0x7E, underflow=1.
- Push 5 entries then clear together with push -> count=0, top_data=0, overflow=underflow=0, push ignored. With STACK_WATERMARK_EN: max_count=5 before clear, 0 after.
- Assert reset_n low asynchronously mid-push burst at count=7 -> outputs zero without a clock edge. After release, a push 0x99 gives count=1, top_data=0x99.

Source files
------------

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack: push, pop, replace-top, registered top-of-stack view and sticky error flags.
// Define STACK_WATERMARK_EN to build the max_count high-watermark register; otherwise max_count is tied to 0.
module lifo_stack_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_WIDTH  = 4,
    parameter int AF_LEVEL    = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   max_count
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(STACK_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   ONE_S   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   TWO_S   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO_A   = ADDR_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem [0:STACK_DEPTH-1];

    logic [ADDR_WIDTH:0]   sp;
    logic [ADDR_WIDTH:0]   sp_next;
    logic [ADDR_WIDTH-1:0] sp_lo;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  do_replace;
    logic                  do_push;
    logic                  do_pop;
    logic                  push_reject;
    logic                  pop_reject;
    logic                  wr_en;

    assign count       = sp;
    assign empty       = (sp == '0);
    assign full        = (sp == DEPTH_C);
    assign almost_full = (sp >= AF_C);

    // Replace-top wins over a plain push whenever there is an entry to replace, even when full.
    assign do_replace  = push && pop && !empty;
    assign do_push     = push && !do_replace && !full;
    assign do_pop      = pop && !push && !empty;
    assign push_reject = push && !do_replace && full;
    assign pop_reject  = pop && empty;

    assign sp_lo   = sp[ADDR_WIDTH-1:0];
    assign wr_addr = do_replace ? (sp_lo - ONE_A) : sp_lo;
    assign wr_en   = reset_n && !clear && (do_push || do_replace);
    assign rd_addr = sp_lo - TWO_A;
    assign rd_data = mem[rd_addr];

    always_comb begin
        sp_next = sp;
        if (clear) begin
            sp_next = '0;
        end else if (do_push) begin
            sp_next = sp + ONE_S;
        end else if (do_pop) begin
            sp_next = sp - ONE_S;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            top_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            sp        <= '0;
            pop_valid <= 1'b0;
            top_data  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            pop_valid <= 1'b0;
            if (do_replace) begin
                pop_data  <= top_data;
                pop_valid <= 1'b1;
                top_data  <= din;
            end else if (do_push) begin
                top_data <= din;
            end else if (do_pop) begin
                pop_data  <= top_data;
                pop_valid <= 1'b1;
                // The entry below the current top becomes visible; nothing is left below a single entry.
                top_data  <= (sp >= TWO_S) ? rd_data : '0;
            end
            if (push_reject) begin
                overflow <= 1'b1;
            end
            if (pop_reject) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef STACK_WATERMARK_EN
    logic [ADDR_WIDTH:0] max_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q <= '0;
        end else if (clear) begin
            max_q <= '0;
        end else if (sp_next > max_q) begin
            max_q <= sp_next;
        end
    end

    assign max_count = max_q;
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Directed bench for lifo_stack_ctrl: expected pops go into a scoreboard queue that a negedge monitor drains.
// Watermark expectations follow STACK_WATERMARK_EN.
module tb_lifo_stack_ctrl;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [7:0] top_data;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic [4:0] max_count;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    lifo_stack_ctrl #(
        .DATA_WIDTH (8),
        .STACK_DEPTH(16),
        .ADDR_WIDTH (4),
        .AF_LEVEL   (12)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .top_data   (top_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .overflow   (overflow),
        .underflow  (underflow),
        .max_count  (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Any pop_valid pulse must match the oldest outstanding expected pop.
    always @(negedge clk) begin
        if (reset_n && pop_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pop_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("pop_data", {24'd0, pop_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic applyStimulus(input logic p, input logic q, input logic [7:0] d,
                                 input logic exp_valid, input logic [7:0] exp_data);
        push = p;
        pop  = q;
        din  = d;
        if (exp_valid) exp_q.push_back(exp_data);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("pop_pending", exp_q.size(), 32'd0);
    endtask

    task automatic applyClear(input logic p, input logic [7:0] d);
        clear = 1'b1;
        push  = p;
        din   = d;
        @(posedge clk);
        #1;
        clear = 1'b0;
        push  = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        din     = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_top", top_data, 0);
        checkOutput("rst_pop_data", pop_data, 0);
        checkOutput("rst_pop_valid", pop_valid, 0);
        checkOutput("rst_flags", {overflow, underflow}, 0);
        checkOutput("rst_max", max_count, 0);
        reset_n = 1'b1;
        #1;

        applyStimulus(1, 0, 8'h11, 0, 8'h00);
        applyStimulus(1, 0, 8'h22, 0, 8'h00);
        applyStimulus(1, 0, 8'h33, 0, 8'h00);
        checkOutput("p3_count", count, 3);
        checkOutput("p3_top", top_data, 8'h33);
        checkOutput("p3_empty", empty, 0);
        applyStimulus(0, 1, 8'h00, 1, 8'h33);
        checkOutput("pop1_top", top_data, 8'h22);
        applyStimulus(0, 1, 8'h00, 1, 8'h22);
        checkOutput("pop2_top", top_data, 8'h11);
        applyStimulus(0, 1, 8'h00, 1, 8'h11);
        checkOutput("pop3_top", top_data, 8'h00);
        checkOutput("pop3_empty", empty, 1);
        checkOutput("pop3_count", count, 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, i[7:0], 0, 8'h00);
            checkOutput("fill_count", count, i + 1);
            checkOutput("fill_almost_full", almost_full, (i + 1) >= 12);
            checkOutput("fill_full", full, (i + 1) == 16);
        end
        applyStimulus(1, 0, 8'hAA, 0, 8'h00);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", count, 16);
        checkOutput("ovf_top", top_data, 8'h0F);

        applyStimulus(1, 1, 8'h55, 1, 8'h0F);
        checkOutput("rep_count", count, 16);
        checkOutput("rep_top", top_data, 8'h55);
        checkOutput("rep_full", full, 1);
        applyStimulus(0, 1, 8'h00, 1, 8'h55);
        checkOutput("rep_pop_top", top_data, 8'h0E);
        checkOutput("rep_pop_count", count, 15);
        checkOutput("ovf_sticky", overflow, 1);
`ifdef STACK_WATERMARK_EN
        checkOutput("max_full", max_count, 16);
`else
        checkOutput("max_full", max_count, 0);
`endif

        applyClear(0, 8'h00);
        checkOutput("clr_count", count, 0);
        checkOutput("clr_ovf", overflow, 0);
        checkOutput("clr_pop_data_hold", pop_data, 8'h55);
        applyStimulus(0, 1, 8'h00, 0, 8'h00);
        checkOutput("unf_flag", underflow, 1);
        checkOutput("unf_count", count, 0);
        applyStimulus(1, 1, 8'h7E, 0, 8'h00);
        checkOutput("pp_empty_count", count, 1);
        checkOutput("pp_empty_top", top_data, 8'h7E);
        checkOutput("pp_empty_unf", underflow, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'hC0 + i[7:0], 0, 8'h00);
        end
        checkOutput("five_count", count, 5);
        checkOutput("five_top", top_data, 8'hC3);
`ifdef STACK_WATERMARK_EN
        checkOutput("five_max", max_count, 5);
`else
        checkOutput("five_max", max_count, 0);
`endif
        applyClear(1, 8'hEE);
        checkOutput("clrp_count", count, 0);
        checkOutput("clrp_top", top_data, 0);
        checkOutput("clrp_flags", {overflow, underflow}, 0);
        checkOutput("clrp_max", max_count, 0);
        checkOutput("clrp_pop_valid", pop_valid, 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 8'h40 + i[7:0], 0, 8'h00);
        end
        checkOutput("burst_count", count, 7);
        push    = 1'b1;
        din     = 8'h47;
        reset_n = 1'b0;
        #1;
        checkOutput("async_count", count, 0);
        checkOutput("async_top", top_data, 0);
        checkOutput("async_empty", empty, 1);
        checkOutput("async_max", max_count, 0);
        @(negedge clk);
        push    = 1'b0;
        reset_n = 1'b1;
        #1;
        applyStimulus(1, 0, 8'h99, 0, 8'h00);
        checkOutput("post_rst_count", count, 1);
        checkOutput("post_rst_top", top_data, 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
